// File: rtl/similarity_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// similarity_frame_scheduler_if
//   Bundles the frame handshake, BRAM read port, similarity-checker controls
//   and compute-engine handshake of the similarity frame scheduler.
//   Modports:
//     slave  - the scheduler itself (drives frame_ready, banks, reads, controls)
//     master - the surrounding environment (frame source, checker, compute engine)
//   Signals:
//     frame_valid/frame_len/frame_ready : frame offer and acceptance
//     cur_bank/wr_bank                  : reference bank and incoming-frame bank
//     rd_en/rd_addr                     : BRAM read port shared by both banks
//     sm_idle/sm_count/sm_done/sm_flag  : similarity checker control and verdict
//     cmp_start/cmp_done                : compute engine handshake
//     skip_pulse/skip_cnt/timeout_err   : status
// -----------------------------------------------------------------------------
interface similarity_frame_scheduler_if #(
   parameter int ADDR_W = 8
);
   logic              frame_valid;
   logic [ADDR_W-1:0] frame_len;
   logic              frame_ready;
   logic              cur_bank;
   logic              wr_bank;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              sm_idle;
   logic [7:0]        sm_count;
   logic              sm_done;
   logic              sm_flag;
   logic              cmp_start;
   logic              cmp_done;
   logic              skip_pulse;
   logic [2:0]        skip_cnt;
   logic              timeout_err;

   modport slave (
      input  frame_valid, frame_len, sm_done, sm_flag, cmp_done,
      output frame_ready, cur_bank, wr_bank, rd_en, rd_addr, sm_idle, sm_count,
             cmp_start, skip_pulse, skip_cnt, timeout_err
   );

   modport master (
      output frame_valid, frame_len, sm_done, sm_flag, cmp_done,
      input  frame_ready, cur_bank, wr_bank, rd_en, rd_addr, sm_idle, sm_count,
             cmp_start, skip_pulse, skip_cnt, timeout_err
   );
endinterface

// File: rtl/similarity_frame_scheduler.sv
// -----------------------------------------------------------------------------
// similarity_frame_scheduler
//   Decides per frame whether the compute engine must run or the frame can be
//   skipped because it is similar to the last computed frame. Every non-first
//   frame is streamed word by word out of the two-bank BRAM into the checker;
//   the checker verdict, a consecutive-skip limit and a watchdog on the checker
//   decide between skip and compute. A computed frame becomes the reference
//   by flipping cur_bank.
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-low reset
//     bus  - similarity_frame_scheduler_if.slave (see interface header)
//   Parameters:
//     ADDR_W   - BRAM word address width
//     MAX_SKIP - consecutive skips allowed before a compute is forced
//     TIMEOUT  - cycles to wait for sm_done before assuming "not similar"
// -----------------------------------------------------------------------------
module similarity_frame_scheduler #(
   parameter int ADDR_W   = 8,
   parameter int MAX_SKIP = 4,
   parameter int TIMEOUT  = 1023
) (
   input logic                         clk,
   input logic                         rst,
   similarity_frame_scheduler_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      WAIT_DONE,
      DECIDE,
      COMPUTE,
      WAIT_CMP
   } state_t;

   state_t            state;
   logic              frame_ready;
   logic              cur_bank;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] len_q;
   logic              sm_idle;
   logic [7:0]        sm_count;
   logic              cmp_start;
   logic              skip_pulse;
   logic [2:0]        skip_cnt;
   logic              timeout_err;
   logic              first;      // no reference frame exists yet
   logic              sim_flag;   // verdict captured from the checker (0 on timeout)
   logic [WD_W-1:0]   wd_cnt;
   logic [ADDR_W-1:0] last_addr;

   assign last_addr = len_q - ADDR_W'(1);

   // NOTE: reset is sampled on the clock edge only (synchronous), so it is
   // tested inside the clocked block rather than in the sensitivity list.
   // NOTE: all state is updated with non-blocking assignments so every
   // register sees the pre-edge values of the others, independent of order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         frame_ready <= 1'b1;
         cur_bank    <= 1'b0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         len_q       <= '0;
         sm_idle     <= 1'b1;
         sm_count    <= '0;
         cmp_start   <= 1'b0;
         skip_pulse  <= 1'b0;
         skip_cnt    <= '0;
         timeout_err <= 1'b0;
         first       <= 1'b1;
         sim_flag    <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         // Pulses default low; only the transitions below raise them.
         cmp_start  <= 1'b0;
         skip_pulse <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.frame_valid && (bus.frame_len != '0)) begin
                  len_q       <= bus.frame_len;
                  sm_count    <= 8'(bus.frame_len);
                  frame_ready <= 1'b0;
                  if (first) begin
                     cmp_start <= 1'b1;
                     state     <= COMPUTE;
                  end else begin
                     sm_idle <= 1'b0;
                     rd_en   <= 1'b1;
                     rd_addr <= '0;
                     state   <= CHECK;
                  end
               end
            end

            CHECK: begin
               if (rd_addr == last_addr) begin
                  rd_en   <= 1'b0;
                  rd_addr <= '0;
                  wd_cnt  <= '0;
                  state   <= WAIT_DONE;
               end else begin
                  rd_addr <= rd_addr + ADDR_W'(1);
               end
            end

            WAIT_DONE: begin
               // sm_done is tested first so it wins over a same-cycle expiry.
               // sm_idle rises on leaving, keeping the checker live exactly
               // for CHECK and WAIT_DONE.
               if (bus.sm_done) begin
                  sim_flag <= bus.sm_flag;
                  sm_idle  <= 1'b1;
                  state    <= DECIDE;
               end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  sim_flag    <= 1'b0;
                  timeout_err <= 1'b1;
                  sm_idle     <= 1'b1;
                  state       <= DECIDE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end

            DECIDE: begin
               if (sim_flag && (skip_cnt < 3'(MAX_SKIP))) begin
                  skip_pulse  <= 1'b1;
                  skip_cnt    <= skip_cnt + 3'd1;
                  frame_ready <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cmp_start <= 1'b1;
                  state     <= COMPUTE;
               end
            end

            // cmp_start is high during this single cycle; cmp_done is not
            // looked at here.
            COMPUTE: state <= WAIT_CMP;

            WAIT_CMP: begin
               if (bus.cmp_done) begin
                  cur_bank    <= ~cur_bank;
                  skip_cnt    <= '0;
                  first       <= 1'b0;
                  frame_ready <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.frame_ready = frame_ready;
   assign bus.cur_bank    = cur_bank;
   assign bus.wr_bank     = ~cur_bank;
   assign bus.rd_en       = rd_en;
   assign bus.rd_addr     = rd_addr;
   assign bus.sm_idle     = sm_idle;
   assign bus.sm_count    = sm_count;
   assign bus.cmp_start   = cmp_start;
   assign bus.skip_pulse  = skip_pulse;
   assign bus.skip_cnt    = skip_cnt;
   assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_similarity_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_similarity_frame_scheduler
//   Directed bench for similarity_frame_scheduler. Stimulus tasks push the
//   expected read/skip/compute events into a scoreboard queue; a monitor
//   process pops and compares whenever the DUT shows rd_en, skip_pulse or
//   cmp_start. Status registers are checked directly after each frame.
// -----------------------------------------------------------------------------
module tb_similarity_frame_scheduler;
   localparam int ADDR_W   = 8;
   localparam int MAX_SKIP = 4;
   localparam int TIMEOUT  = 1023;
   localparam int HOLD     = 32'h0000_FFFF;  // never raise sm_done

   logic clk = 1'b0;
   logic rst = 1'b0;

   similarity_frame_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

   similarity_frame_scheduler #(
      .ADDR_W  (ADDR_W),
      .MAX_SKIP(MAX_SKIP),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   typedef enum int {EV_READ, EV_SKIP, EV_CMP} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       addr;
      int       bank;
      int       skip;
      int       err;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;

   // Reference model state
   bit  exp_first;
   int  exp_bank;
   int  exp_skip;
   int  exp_err;
   int  last_len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input ev_kind_t k);
      ev_t e;
      if (sb.size() == 0) begin
         check($sformatf("unexpected_event_%0d", k), 1, 0);
         return;
      end
      e = sb.pop_front();
      check("event_kind", k, e.kind);
      case (k)
         EV_READ: begin
            check("rd_addr", bus.rd_addr, e.addr);
            check("sm_idle_during_read", bus.sm_idle, 0);
         end
         EV_SKIP: begin
            check("skip_cnt_at_skip", bus.skip_cnt, e.skip);
            check("cur_bank_at_skip", bus.cur_bank, e.bank);
         end
         default: begin
            check("timeout_err_at_cmp_start", bus.timeout_err, e.err);
            check("cur_bank_at_cmp_start", bus.cur_bank, e.bank);
            check("skip_cnt_at_cmp_start", bus.skip_cnt, e.skip);
         end
      endcase
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.rd_en === 1'b1)      expect_ev(EV_READ);
         if (bus.skip_pulse === 1'b1) expect_ev(EV_SKIP);
         if (bus.cmp_start === 1'b1)  expect_ev(EV_CMP);
      end
   end

   // Hard stop if something hangs despite the bounded waits.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

   task automatic send_frame(input int len);
      int n = 0;
      while (!bus.frame_ready && n < 50) begin
         tick();
         n++;
      end
      check("frame_ready_before_send", bus.frame_ready, 1);
      bus.frame_valid = 1'b1;
      bus.frame_len   = ADDR_W'(len);
      tick();
      bus.frame_valid = 1'b0;
      bus.frame_len   = '0;
      check("frame_ready_after_accept", bus.frame_ready, 0);
      check("sm_count_latched", bus.sm_count, len);
      last_len = len;
   endtask

   task automatic do_check(input int len, input bit flag, input int delay);
      int n = 0;
      check("rd_en_after_accept", bus.rd_en, 1);
      while (bus.rd_en && n < len + 4) begin
         tick();
         n++;
      end
      check("read_cycles", n, len);
      check("sm_idle_in_wait_done", bus.sm_idle, 0);
      if (delay != HOLD) begin
         repeat (delay) tick();
         bus.sm_done = 1'b1;
         bus.sm_flag = flag;
         tick();
         bus.sm_done = 1'b0;
         bus.sm_flag = 1'b0;
         check("sm_idle_after_done", bus.sm_idle, 1);
      end else begin
         n = 0;
         while (!bus.cmp_start && n < 2000) begin
            tick();
            n++;
         end
         check("timeout_to_cmp_start_cycles", n, TIMEOUT + 1);
         check("timeout_err_set", bus.timeout_err, 1);
      end
   endtask

   task automatic do_compute(input int len, input bit poke);
      int n = 0;
      while (!bus.cmp_start && n < 20) begin
         tick();
         n++;
      end
      check("cmp_start_seen", bus.cmp_start, 1);
      if (poke) begin
         // cmp_done during COMPUTE and a frame offer during WAIT_CMP are ignored
         bus.cmp_done    = 1'b1;
         bus.frame_valid = 1'b1;
         bus.frame_len   = ADDR_W'(9);
         tick();
         bus.cmp_done = 1'b0;
         check("cmp_start_pulse_width", bus.cmp_start, 0);
         tick();
         tick();
         check("cmp_done_in_compute_ignored", bus.frame_ready, 0);
         check("frame_in_wait_cmp_sm_count", bus.sm_count, len);
         check("frame_in_wait_cmp_bank", bus.cur_bank, exp_bank);
         bus.frame_valid = 1'b0;
         bus.frame_len   = '0;
      end else begin
         tick();
         check("cmp_start_pulse_width", bus.cmp_start, 0);
      end
      bus.cmp_done = 1'b1;
      tick();
      bus.cmp_done = 1'b0;
   endtask

   task automatic run_frame(input int len, input bit flag, input int delay, input bit poke);
      bit to;
      bit skip;
      int n = 0;
      if (exp_first) begin
         sb.push_back('{EV_CMP, 0, exp_bank, exp_skip, exp_err});
         send_frame(len);
         check("first_frame_cmp_start", bus.cmp_start, 1);
         check("first_frame_no_read", bus.rd_en, 0);
         do_compute(len, poke);
         exp_bank  = exp_bank ^ 1;
         exp_skip  = 0;
         exp_first = 1'b0;
      end else begin
         to   = (delay == HOLD);
         skip = flag && !to && (exp_skip < MAX_SKIP);
         for (int i = 0; i < len; i++) sb.push_back('{EV_READ, i, 0, 0, 0});
         if (to) exp_err = 1;
         if (skip) sb.push_back('{EV_SKIP, 0, exp_bank, exp_skip + 1, 0});
         else      sb.push_back('{EV_CMP, 0, exp_bank, exp_skip, exp_err});
         send_frame(len);
         do_check(len, flag, delay);
         if (skip) begin
            exp_skip++;
         end else begin
            do_compute(len, poke);
            exp_bank = exp_bank ^ 1;
            exp_skip = 0;
         end
      end
      while (!bus.frame_ready && n < 10) begin
         tick();
         n++;
      end
      check("frame_ready_after_frame", bus.frame_ready, 1);
      check("cur_bank_after_frame", bus.cur_bank, exp_bank);
      check("wr_bank_after_frame", bus.wr_bank, exp_bank ^ 1);
      check("skip_cnt_after_frame", bus.skip_cnt, exp_skip);
      check("timeout_err_after_frame", bus.timeout_err, exp_err);
      check("sm_idle_after_frame", bus.sm_idle, 1);
      check("rd_en_after_frame", bus.rd_en, 0);
   endtask

   task automatic model_reset();
      exp_first = 1'b1;
      exp_bank  = 0;
      exp_skip  = 0;
      exp_err   = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_frame_ready"}, bus.frame_ready, 1);
      check({tag, "_cur_bank"}, bus.cur_bank, 0);
      check({tag, "_wr_bank"}, bus.wr_bank, 1);
      check({tag, "_rd_en"}, bus.rd_en, 0);
      check({tag, "_rd_addr"}, bus.rd_addr, 0);
      check({tag, "_sm_idle"}, bus.sm_idle, 1);
      check({tag, "_sm_count"}, bus.sm_count, 0);
      check({tag, "_cmp_start"}, bus.cmp_start, 0);
      check({tag, "_skip_pulse"}, bus.skip_pulse, 0);
      check({tag, "_skip_cnt"}, bus.skip_cnt, 0);
      check({tag, "_timeout_err"}, bus.timeout_err, 0);
   endtask

   initial begin
      bus.frame_valid = 1'b0;
      bus.frame_len   = '0;
      bus.sm_done     = 1'b0;
      bus.sm_flag     = 1'b0;
      bus.cmp_done    = 1'b0;
      model_reset();

      // Reset state
      rst = 1'b0;
      repeat (2) tick();
      check_reset_state("reset");
      rst = 1'b1;

      // 1: first frame is computed without reads; cur_bank -> 1
      run_frame(4, 1'b0, 0, 1'b0);

      // 2: similar frame is skipped after 4 reads
      run_frame(4, 1'b1, 0, 1'b0);

      // 3: not-similar frame computes, then five similar: four skips, fifth forced
      run_frame(3, 1'b0, 2, 1'b0);
      for (int i = 0; i < 5; i++) run_frame(2, 1'b1, 1, 1'b0);

      // 4: sm_done exactly at the expiry cycle wins, then a real timeout
      run_frame(5, 1'b1, TIMEOUT - 1, 1'b0);
      run_frame(5, 1'b1, HOLD, 1'b0);

      // 5: zero-length frame ignored; cmp_done in COMPUTE and frame in WAIT_CMP ignored
      bus.frame_valid = 1'b1;
      bus.frame_len   = '0;
      tick();
      bus.frame_valid = 1'b0;
      tick();
      check("zero_len_frame_ready", bus.frame_ready, 1);
      check("zero_len_sm_count", bus.sm_count, last_len);
      check("zero_len_sm_idle", bus.sm_idle, 1);
      run_frame(7, 1'b0, 0, 1'b1);

      // 6: reset in the middle of CHECK at rd_addr=2
      for (int i = 0; i < 3; i++) sb.push_back('{EV_READ, i, 0, 0, 0});
      send_frame(6);
      tick();
      tick();
      check("rd_addr_before_reset", bus.rd_addr, 2);
      rst = 1'b0;
      tick();
      check_reset_state("mid_reset");
      rst = 1'b1;
      model_reset();
      run_frame(3, 1'b1, 0, 1'b0);

      tick();
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
